// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 16-bit registered ALU: default datapath widths
// and the opcode encoding used by the control unit.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int OPW   = 4;

  typedef enum logic [3:0] {
    OP_ADD       = 4'd0,
    OP_SUB       = 4'd1,
    OP_BYTEMERGE = 4'd2,
    OP_MUL       = 4'd3,
    OP_DIV       = 4'd4,
    OP_MOD       = 4'd5,
    OP_AND       = 4'd6,
    OP_OR        = 4'd7,
    OP_XOR       = 4'd8,
    OP_NOT       = 4'd9,
    OP_SHL       = 4'd10,
    OP_SHR       = 4'd11,
    OP_SRA       = 4'd12,
    OP_SLTU      = 4'd13,
    OP_PASSA     = 4'd14,
    OP_PASSB     = 4'd15
  } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu16_comb.sv
// -----------------------------------------------------------------------------
// alu16_comb
// Pure combinational opcode decode and compute for the ALU. Produces the value
// the output registers will load on the next valid cycle.
//
// Ports:
//   opcode           in   operation select (alu_op_e encoding)
//   operand1         in   operand A, unsigned
//   operand2         in   operand B, unsigned
//   result_next      out  computed result, truncated to WIDTH bits
//   zero_next        out  result_next == 0
//   carry_next       out  carry (ADD) / borrow (SUB), 0 for other opcodes
//   div_by_zero_next out  DIV/MOD with operand2 == 0
// -----------------------------------------------------------------------------
module alu16_comb #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] result_next,
  output logic             zero_next,
  output logic             carry_next,
  output logic             div_by_zero_next
);

  import alu_pkg::*;

  localparam int SHW  = $clog2(WIDTH);
  localparam int HALF = WIDTH / 2;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] sra_val;
  logic [SHW-1:0]   shamt;
  logic             b_zero;

  // Extra top bit carries the carry-out for ADD; for SUB it is set exactly
  // when the subtraction wraps, i.e. the borrow (A < B).
  assign sum_ext  = {1'b0, operand1} + {1'b0, operand2};
  assign diff_ext = {1'b0, operand1} - {1'b0, operand2};

  // Only the low WIDTH bits of the product are ever needed.
  assign prod_lo = operand1 * operand2;

  // Divide-by-zero is forced to 0 explicitly rather than relying on whatever
  // the divider produces for a zero divisor.
  assign b_zero = (operand2 == '0);
  assign quot   = b_zero ? '0 : (operand1 / operand2);
  assign rem    = b_zero ? '0 : (operand1 % operand2);

  // Shift amount uses only the low bits of B; upper bits are ignored.
  assign shamt   = operand2[SHW-1:0];
  assign sra_val = $unsigned($signed(operand1) >>> shamt);

  always_comb begin
    result_next      = '0;
    carry_next       = 1'b0;
    div_by_zero_next = 1'b0;

    case (alu_op_e'(opcode))
      OP_ADD: begin
        result_next = sum_ext[WIDTH-1:0];
        carry_next  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        result_next = diff_ext[WIDTH-1:0];
        carry_next  = diff_ext[WIDTH];
      end
      OP_BYTEMERGE: result_next = {operand1[HALF-1:0], operand2[HALF-1:0]};
      OP_MUL:       result_next = prod_lo;
      OP_DIV: begin
        result_next      = quot;
        div_by_zero_next = b_zero;
      end
      OP_MOD: begin
        result_next      = rem;
        div_by_zero_next = b_zero;
      end
      OP_AND:   result_next = operand1 & operand2;
      OP_OR:    result_next = operand1 | operand2;
      OP_XOR:   result_next = operand1 ^ operand2;
      OP_NOT:   result_next = ~operand1;
      OP_SHL:   result_next = operand1 << shamt;
      OP_SHR:   result_next = operand1 >> shamt;
      OP_SRA:   result_next = sra_val;
      OP_SLTU:  result_next = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
      OP_PASSA: result_next = operand1;
      OP_PASSB: result_next = operand2;
      default:  result_next = '0;
    endcase
  end

  assign zero_next = (result_next == '0);

endmodule : alu16_comb

// File: rtl/alu16.sv
// -----------------------------------------------------------------------------
// alu16
// 16-bit registered integer ALU, one-cycle latency. The combinational core
// computes a candidate result every cycle; this level only owns the output
// registers and the valid pipeline.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   opcode/operands valid this cycle
//   opcode       in   operation select
//   operand1     in   operand A, unsigned
//   operand2     in   operand B, unsigned
//   result       out  registered result
//   out_valid    out  in_valid delayed one cycle
//   zero         out  registered result == 0
//   carry        out  carry/borrow (ADD/SUB only)
//   div_by_zero  out  DIV/MOD issued with B == 0
// -----------------------------------------------------------------------------
module alu16 #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] result_next;
  logic             zero_next;
  logic             carry_next;
  logic             div_by_zero_next;

  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             carry_reg;
  logic             div_by_zero_reg;
  logic             out_valid_reg;

  alu16_comb #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_comb (
    .opcode           (opcode),
    .operand1         (operand1),
    .operand2         (operand2),
    .result_next      (result_next),
    .zero_next        (zero_next),
    .carry_next       (carry_next),
    .div_by_zero_next (div_by_zero_next)
  );

  // Valid tracks in_valid every cycle; the data registers load only on a
  // valid cycle so result and flags hold through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg   <= 1'b0;
      result_reg      <= '0;
      zero_reg        <= 1'b0;
      carry_reg       <= 1'b0;
      div_by_zero_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        result_reg      <= result_next;
        zero_reg        <= zero_next;
        carry_reg       <= carry_next;
        div_by_zero_reg <= div_by_zero_next;
      end
    end
  end

  assign result      = result_reg;
  assign out_valid   = out_valid_reg;
  assign zero        = zero_reg;
  assign carry       = carry_reg;
  assign div_by_zero = div_by_zero_reg;

endmodule : alu16

// File: tb/tb_alu16.sv
// -----------------------------------------------------------------------------
// tb_alu16
// Directed self-checking bench for alu16. Inputs change on the falling edge;
// outputs are sampled 1 time unit after the rising edge that registers them.
// -----------------------------------------------------------------------------
module tb_alu16;

  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [15:0] operand1 = 16'd0;
  logic [15:0] operand2 = 16'd0;
  logic [15:0] result;
  logic        out_valid;
  logic        zero;
  logic        carry;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    alu_op_e     op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        d;
  } vec_t;

  always #5 clk = ~clk;

  alu16 #(
    .WIDTH (16),
    .OPW   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .opcode      (opcode),
    .operand1    (operand1),
    .operand2    (operand2),
    .result      (result),
    .out_valid   (out_valid),
    .zero        (zero),
    .carry       (carry),
    .div_by_zero (div_by_zero)
  );

  function automatic vec_t mk(alu_op_e op, logic [15:0] a, logic [15:0] b,
                              logic [15:0] res, logic c, logic z, logic d);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.c = c; v.z = z; v.d = d;
    return v;
  endfunction

  // Present one valid operation and return just after the registering edge.
  task automatic issue(input alu_op_e op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with deliberately different operands on the bus.
  task automatic idle(input alu_op_e op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = op;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    opcode   = OP_ADD;
    operand1 = 16'd100;
    operand2 = 16'd100;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== 16'h0000) begin
      errors++; $display("FAIL reset_result got %h exp %h", result, 16'h0000);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    checks++;
    if ({zero, carry, div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got z%b c%b d%b exp 000", zero, carry, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, 16'd100, 16'd100);
    $display("reset release: ADD 100+100 -> result %0d out_valid %b", result, out_valid);
    checks++;
    if ({out_valid, result, carry, zero, div_by_zero} !== {1'b1, 16'd200, 3'b000}) begin
      errors++;
      $display("FAIL first_add got v%b %h c%b z%b d%b exp v1 00c8 c0 z0 d0",
               out_valid, result, carry, zero, div_by_zero);
    end
  endtask

  task automatic test_ops();
    vec_t v[$];
    v.push_back(mk(OP_SUB,       16'd100,  16'd50,   16'd50,   1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_SUB,       16'd50,   16'd100,  16'hFFCE, 1'b1, 1'b0, 1'b0));
    v.push_back(mk(OP_ADD,       16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0));
    v.push_back(mk(OP_SUB,       16'd5,    16'd5,    16'h0000, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(OP_BYTEMERGE, 16'hFFFF, 16'h0012, 16'hFF12, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_MUL,       16'd40,   16'd40,   16'd1600, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_MUL,       16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(OP_DIV,       16'd1600, 16'd40,   16'd40,   1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_DIV,       16'd1600, 16'd0,    16'h0000, 1'b0, 1'b1, 1'b1));
    v.push_back(mk(OP_MOD,       16'd1601, 16'd40,   16'd1,    1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_MOD,       16'd1234, 16'd0,    16'h0000, 1'b0, 1'b1, 1'b1));
    v.push_back(mk(OP_AND,       16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_OR,        16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_XOR,       16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_NOT,       16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_SHL,       16'h0001, 16'd15,   16'h8000, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_SHL,       16'h0001, 16'h0011, 16'h0002, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_SHR,       16'h8000, 16'd4,    16'h0800, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_SRA,       16'h8000, 16'd4,    16'hF800, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_SRA,       16'h4000, 16'd4,    16'h0400, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_SLTU,      16'd3,    16'd5,    16'h0001, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_SLTU,      16'd5,    16'd3,    16'h0000, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(OP_SLTU,      16'd5,    16'd5,    16'h0000, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(OP_PASSA,     16'h1234, 16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_PASSB,     16'h1234, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(OP_PASSA,     16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0));
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b);
      $display("op %s a %h b %h -> result %h c%b z%b d%b v%b", v[i].op.name(),
               v[i].a, v[i].b, result, carry, zero, div_by_zero, out_valid);
      checks++;
      if ({out_valid, result, carry, zero, div_by_zero} !==
          {1'b1, v[i].res, v[i].c, v[i].z, v[i].d}) begin
        errors++;
        $display("FAIL op_%s a %h b %h got v%b %h c%b z%b d%b exp v1 %h c%b z%b d%b",
                 v[i].op.name(), v[i].a, v[i].b, out_valid, result, carry, zero,
                 div_by_zero, v[i].res, v[i].c, v[i].z, v[i].d);
      end
    end
  endtask

  task automatic test_hold();
    issue(OP_SUB, 16'd50, 16'd100);
    idle(OP_PASSA, 16'h0000, 16'h0000);
    $display("hold after SUB: result %h carry %b out_valid %b", result, carry, out_valid);
    checks++;
    if ({out_valid, result, carry, zero, div_by_zero} !== {1'b0, 16'hFFCE, 3'b100}) begin
      errors++;
      $display("FAIL hold_sub got v%b %h c%b z%b d%b exp v0 ffce c1 z0 d0",
               out_valid, result, carry, zero, div_by_zero);
    end
    idle(OP_ADD, 16'h0001, 16'h0002);
    checks++;
    if ({out_valid, result, carry} !== {1'b0, 16'hFFCE, 1'b1}) begin
      errors++;
      $display("FAIL hold_sub_2 got v%b %h c%b exp v0 ffce c1", out_valid, result, carry);
    end
    issue(OP_DIV, 16'd7, 16'd0);
    idle(OP_PASSA, 16'd5, 16'd5);
    $display("hold after DIV/0: result %h dbz %b zero %b", result, div_by_zero, zero);
    checks++;
    if ({out_valid, result, carry, zero, div_by_zero} !== {1'b0, 16'h0000, 3'b011}) begin
      errors++;
      $display("FAIL hold_div0 got v%b %h c%b z%b d%b exp v0 0000 c0 z1 d1",
               out_valid, result, carry, zero, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    alu_op_e     ops [8] = '{OP_ADD, OP_SUB, OP_MUL, OP_XOR, OP_SHL, OP_DIV, OP_MOD, OP_OR};
    logic [15:0] as  [8] = '{16'd1, 16'd10, 16'd3, 16'hAAAA, 16'd3, 16'd100, 16'd100, 16'h1000};
    logic [15:0] bs  [8] = '{16'd2, 16'd3,  16'd7, 16'h5555, 16'd4, 16'd7,   16'd7,   16'h0001};
    logic [15:0] exp [8] = '{16'd3, 16'd7,  16'd21, 16'hFFFF, 16'h0030, 16'd14, 16'd2, 16'h1001};
    int valid_run = 0;
    idle(OP_ADD, 16'd0, 16'd0);
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i]);
      if (out_valid === 1'b1) valid_run++;
      $display("stream %0d op %s -> result %h out_valid %b", i, ops[i].name(), result, out_valid);
      checks++;
      if ({out_valid, result} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL stream_%0d got v%b %h exp v1 %h", i, out_valid, result, exp[i]);
      end
    end
    idle(OP_ADD, 16'd9, 16'd9);
    checks++;
    if (valid_run != 8 || out_valid !== 1'b0 || result !== 16'h1001) begin
      errors++;
      $display("FAIL stream_end got run %0d v%b %h exp run 8 v0 1001", valid_run, out_valid, result);
    end
  endtask

  task automatic test_async_reset();
    issue(OP_ADD, 16'd100, 16'd100);
    #2;
    rst_n = 1'b0;   // mid-cycle, well away from any clock edge
    #1;
    $display("async reset mid-cycle: result %h out_valid %b", result, out_valid);
    checks++;
    if ({out_valid, result, carry, zero, div_by_zero} !== {1'b0, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL async_reset got v%b %h c%b z%b d%b exp all 0",
               out_valid, result, carry, zero, div_by_zero);
    end
    issue(OP_SUB, 16'd1, 16'd2);
    checks++;
    if ({out_valid, result, carry} !== {1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_held got v%b %h c%b exp v0 0000 c0", out_valid, result, carry);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_PASSB, 16'h1111, 16'h00AA);
    $display("after reset release: PASSB -> result %h", result);
    checks++;
    if ({out_valid, result, zero} !== {1'b1, 16'h00AA, 1'b0}) begin
      errors++;
      $display("FAIL post_reset got v%b %h z%b exp v1 00aa z0", out_valid, result, zero);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_hold();
    test_back_to_back();
    test_async_reset();
    @(negedge clk);
    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu16

// File: doc/alu16.md
Name:
alu16

Overview:
- 16-bit registered integer ALU: takes a 4-bit opcode and two 16-bit unsigned operands, produces a 16-bit result plus status flags.
- Sits in the datapath downstream of the control unit, which supplies the opcode and operands.
- One-cycle latency; all outputs are registered.

Parameters:
- WIDTH, 16, operand/result width (all requirements below stated for 16).
- OPW, 4, opcode width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  opcode/operands valid this cycle.
- opcode  input  4  operation select.
- operand1  input  16  first operand (A), unsigned.
- operand2  input  16  second operand (B), unsigned.
- result  output  16  registered result.
- out_valid  output  1  result valid (in_valid delayed one cycle).
- zero  output  1  result == 0.
- carry  output  1  carry/borrow out (ADD/SUB only, else 0).
- div_by_zero  output  1  DIV/MOD issued with B == 0.

Behaviour:
- Reset (rst_n low, asynchronous): result=0, out_valid=0, zero=0, carry=0, div_by_zero=0. Deassertion is synchronised externally.
- Sampling: on each rising clk with in_valid=1, compute from opcode/A/B and register all outputs. out_valid=1 in the next cycle.
- When in_valid=0: out_valid=0 next cycle; result and flags hold their last values.
- Opcodes (all arithmetic unsigned, result truncated to 16 bits):
  - 0 ADD: A+B. carry = bit 16.
  - 1 SUB: A-B, mod 2^16 (50-100 = 0xFFCE). carry = borrow (A<B).
  - 2 BYTEMERGE: {A[7:0], B[7:0]}, i.e. (A<<8)|B[7:0] (0xFFFF,0x0012 -> 0xFF12).
  - 3 MUL: low 16 bits of A*B.
  - 4 DIV: A/B, truncating. If B==0: result=0, div_by_zero=1.
  - 5 MOD: A%B. If B==0: result=0, div_by_zero=1.
  - 6 AND; 7 OR; 8 XOR; 9 NOT: ~A (B ignored).
  - 10 SHL: A << B[3:0].
  - 11 SHR: logical, A >> B[3:0].
  - 12 SRA: arithmetic, A >>> B[3:0] (A treated as signed).
  - 13 SLTU: result = {15'b0, A<B}.
  - 14 PASSA: A.
  - 15 PASSB: B.
- zero is computed from the new registered result for every opcode.
- div_by_zero is 0 for all opcodes other than DIV/MOD.
- Back-to-back valid operations: one result per cycle, no stalls.
- Reset asserted mid-operation: the pending result is discarded; outputs clear immediately.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e (OP_ADD=0 ... OP_PASSB=15);
  - localparam WIDTH=16.
- One combinational sub-module, alu16_comb: pure opcode decode and compute, producing next-result and next-flags.
- Top module alu16 holds only the output registers, the async reset and the valid pipeline.

Test Plan:
- Reset: hold rst_n=0, apply valid stimulus -> all outputs 0. Release, ADD 100+100 -> next cycle result=200, out_valid=1, carry=0, zero=0.
- SUB: 100-50 -> 50, carry=0. Then 50-100 -> 0xFFCE, carry=1. Then 0xFFFF+1 (ADD) -> 0x0000, carry=1, zero=1.
- BYTEMERGE 0xFFFF,0x0012 -> 0xFF12. MUL 40*40 -> 1600. MUL 0x0100*0x0100 -> 0x0000, zero=1.
- DIV 1600/40 -> 40, div_by_zero=0. DIV 1600/0 -> 0, div_by_zero=1. MOD 1601%40 -> 1. MOD x%0 -> 0, div_by_zero=1.
- Logic/shift: AND 0xF0F0,0xFF00 -> 0xF000. SHL 0x0001 by 15 -> 0x8000. SRA 0x8000 by 4 -> 0xF800. SHR 0x8000 by 4 -> 0x0800. SLTU 3,5 -> 1.
- Control: in_valid=0 -> out_valid drops and result holds. Assert rst_n=0 between clock edges -> outputs clear without a clock edge. Streaming 8 back-to-back ops -> 8 consecutive out_valid cycles with matching results.
